alu_share_arbiter: RTL and testbench

- Shares one combinational 64-bit ALU (existing alu module) among NREQ thread requesters in the 2-core/4-thread pipeline.
- Round-robin arbitration with per-requester valid/ready handshake.
- Operation executes in the grant cycle; result and flags are registered into a single output stage with backpressure.
- Sits between thread issue slots and writeback; replaces per-thread ALU copies.

---
 rtl/alu_pkg.sv | 24 ++
 rtl/alu.sv | 43 ++++
 rtl/rr_arbiter.sv | 32 +++
 rtl/alu_share_arbiter.sv | 101 ++++++++++
 tb/tb_alu_share_arbiter.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Opcode encoding and datapath width for the shared 64-bit ALU.
package alu_pkg;

  localparam int XLEN   = 64;
  localparam int OP_MAX = 9;

  typedef enum logic [3:0] {
    DUMMY = 4'd0,
    ADD   = 4'd1,
    SUB   = 4'd2,
    AND   = 4'd3,
    OR    = 4'd4,
    XOR   = 4'd5,
    SLL   = 4'd6,
    SRL   = 4'd7,
    SLT   = 4'd8,
    SLTU  = 4'd9
  } alu_op_e;

  function automatic logic op_legal(input logic [3:0] op);
    return (op != 4'd0) && (op <= 4'(OP_MAX));
  endfunction

endpackage

// File: rtl/alu.sv
// Combinational 64-bit ALU; unknown opcodes give a zero result with o_err set.
module alu
  import alu_pkg::*;
(
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  input  logic [3:0]      i_op,
  output logic [XLEN-1:0] o_result,
  output logic            o_overflow,
  output logic            o_err
);

  logic [XLEN-1:0] w_sum;
  logic [XLEN-1:0] w_diff;

  assign w_sum  = i_a + i_b;
  assign w_diff = i_a - i_b;

  always_comb begin
    o_result   = '0;
    o_overflow = 1'b0;
    o_err      = !op_legal(i_op);
    case (i_op)
      ADD: begin
        o_result   = w_sum;
        o_overflow = (i_a[XLEN-1] == i_b[XLEN-1]) && (w_sum[XLEN-1] != i_a[XLEN-1]);
      end
      SUB: begin
        o_result   = w_diff;
        o_overflow = (i_a[XLEN-1] != i_b[XLEN-1]) && (w_diff[XLEN-1] != i_a[XLEN-1]);
      end
      AND:  o_result = i_a & i_b;
      OR:   o_result = i_a | i_b;
      XOR:  o_result = i_a ^ i_b;
      SLL:  o_result = i_a << i_b[5:0];
      SRL:  o_result = i_a >> i_b[5:0];
      SLT:  o_result = {{(XLEN-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
      SLTU: o_result = {{(XLEN-1){1'b0}}, (i_a < i_b)};
      default: o_result = '0;
    endcase
  end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin picker: first requester at or after i_ptr, wrapping modulo NREQ.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IDW-1:0]  i_ptr,
  output logic [NREQ-1:0] o_grant,
  output logic [IDW-1:0]  o_idx,
  output logic            o_any
);

  int w_pos;

  // Scan from the farthest offset down so the nearest requester wins last.
  always_comb begin
    o_idx   = '0;
    o_any   = 1'b0;
    o_grant = '0;
    w_pos   = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      w_pos = int'(i_ptr) + k;
      if (w_pos >= NREQ) w_pos = w_pos - NREQ;
      if (i_req[w_pos[IDW-1:0]]) begin
        o_idx = w_pos[IDW-1:0];
        o_any = 1'b1;
      end
    end
    if (o_any) o_grant[o_idx] = 1'b1;
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one ALU among NREQ requesters; op runs in the grant cycle, result is
// registered in a single output stage with backpressure.
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*XLEN-1:0] req_a,
  input  logic [NREQ*XLEN-1:0] req_b,
  input  logic [NREQ*4-1:0]    req_aluop,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IDW-1:0]       rsp_id,
  output logic [XLEN-1:0]      rsp_result,
  output logic                 rsp_zero,
  output logic                 rsp_negative,
  output logic                 rsp_overflow,
  output logic                 rsp_err
);

  logic            r_rsp_valid;
  logic [IDW-1:0]  r_rsp_id;
  logic [IDW-1:0]  r_ptr;
  logic [XLEN-1:0] r_result;
  logic            r_zero, r_negative, r_overflow, r_err;

  logic [NREQ-1:0] w_grant;
  logic [IDW-1:0]  w_idx;
  logic            w_any;
  logic            w_out_free;
  logic            w_hs;
  logic [XLEN-1:0] w_a, w_b, w_result;
  logic [3:0]      w_op;
  logic            w_overflow, w_err;
  logic [IDW-1:0]  w_ptr_next;

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .i_req   (req_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  assign w_out_free = !r_rsp_valid || rsp_ready;
  assign req_ready  = (rst || !w_out_free) ? '0 : w_grant;
  assign w_hs       = w_any && w_out_free && !rst;

  assign w_a  = req_a[int'(w_idx)*XLEN +: XLEN];
  assign w_b  = req_b[int'(w_idx)*XLEN +: XLEN];
  assign w_op = req_aluop[int'(w_idx)*4 +: 4];

  alu u_alu (
    .i_a        (w_a),
    .i_b        (w_b),
    .i_op       (w_op),
    .o_result   (w_result),
    .o_overflow (w_overflow),
    .o_err      (w_err)
  );

  assign w_ptr_next = (int'(w_idx) == NREQ - 1) ? '0 : w_idx + IDW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_ptr       <= '0;
      r_result    <= '0;
      r_zero      <= 1'b0;
      r_negative  <= 1'b0;
      r_overflow  <= 1'b0;
      r_err       <= 1'b0;
    end else if (w_hs) begin
      r_rsp_valid <= 1'b1;
      r_rsp_id    <= w_idx;
      r_ptr       <= w_ptr_next;
      r_result    <= w_result;
      r_zero      <= (w_result == '0);
      r_negative  <= w_result[XLEN-1];
      r_overflow  <= w_overflow;
      r_err       <= w_err;
    end else if (rsp_ready) begin
      r_rsp_valid <= 1'b0;
    end
  end

  assign rsp_valid    = r_rsp_valid;
  assign rsp_id       = r_rsp_id;
  assign rsp_result   = r_result;
  assign rsp_zero     = r_zero;
  assign rsp_negative = r_negative;
  assign rsp_overflow = r_overflow;
  assign rsp_err      = r_err;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed and randomized checks of alu_share_arbiter against a behavioural model.
module tb_alu_share_arbiter;
  import alu_pkg::*;

  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam logic signed [64:0] MAXS = 65'sh0_7FFF_FFFF_FFFF_FFFF;
  localparam logic signed [64:0] MINS = -65'sh0_8000_0000_0000_0000;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid, req_ready;
  logic [NREQ*64-1:0] req_a, req_b;
  logic [NREQ*4-1:0] req_aluop;
  logic              rsp_valid, rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [63:0]       rsp_result;
  logic              rsp_zero, rsp_negative, rsp_overflow, rsp_err;

  always #5 clk = ~clk;

  alu_share_arbiter #(.NREQ(NREQ)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_aluop(req_aluop),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_negative(rsp_negative),
    .rsp_overflow(rsp_overflow), .rsp_err(rsp_err)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference state: priority pointer and the pending response.
  int          m_ptr = 0;
  logic        m_valid = 1'b0;
  int          m_id = 0;
  logic [63:0] m_res = '0;
  logic        m_zero = 1'b0, m_neg = 1'b0, m_ovf = 1'b0, m_err = 1'b0;
  logic        last_hs = 1'b0;
  int          last_win = -1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic void ref_alu(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                                  output logic [63:0] r, output logic ovf, output logic err);
    logic signed [64:0] wide;
    r = '0; ovf = 1'b0; err = 1'b0; wide = '0;
    case (op)
      4'd1: begin wide = $signed({a[63], a}) + $signed({b[63], b}); r = wide[63:0]; ovf = (wide > MAXS) || (wide < MINS); end
      4'd2: begin wide = $signed({a[63], a}) - $signed({b[63], b}); r = wide[63:0]; ovf = (wide > MAXS) || (wide < MINS); end
      4'd3: r = a & b;
      4'd4: r = a | b;
      4'd5: r = a ^ b;
      4'd6: r = a << b[5:0];
      4'd7: r = a >> b[5:0];
      4'd8: r = ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
      4'd9: r = (a < b) ? 64'd1 : 64'd0;
      default: err = 1'b1;
    endcase
  endfunction

  task automatic set_req(input int i, input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
    req_valid[i] = 1'b1;
    req_aluop[i*4 +: 4] = op;
    req_a[i*64 +: 64] = a;
    req_b[i*64 +: 64] = b;
  endtask

  task automatic drop_winner();
    if (last_hs) req_valid[last_win] = 1'b0;
  endtask

  // One clock: check grant at the falling edge, then the registered response.
  task automatic step();
    logic [NREQ-1:0] exp_rdy;
    logic [63:0] a, b;
    logic [3:0] op;
    int win;
    logic free;
    a = '0; b = '0; op = '0;
    @(negedge clk);
    exp_rdy = '0;
    win = -1;
    if (!rst) begin
      free = !m_valid || rsp_ready;
      for (int k = 0; k < NREQ; k++) begin
        int j;
        j = (m_ptr + k) % NREQ;
        if (win < 0 && req_valid[j]) win = j;
      end
      if (free && win >= 0) exp_rdy[win] = 1'b1;
    end
    chk("req_ready", 64'(req_ready), 64'(exp_rdy));
    last_hs  = (exp_rdy != '0);
    last_win = win;
    if (last_hs) begin
      a  = req_a[win*64 +: 64];
      b  = req_b[win*64 +: 64];
      op = req_aluop[win*4 +: 4];
    end
    @(posedge clk);
    #1;
    if (rst) begin
      m_valid = 1'b0; m_ptr = 0; m_id = 0; m_res = '0;
      m_zero = 1'b0; m_neg = 1'b0; m_ovf = 1'b0; m_err = 1'b0;
    end else if (last_hs) begin
      ref_alu(op, a, b, m_res, m_ovf, m_err);
      m_zero  = (m_res == 64'd0);
      m_neg   = m_res[63];
      m_id    = win;
      m_valid = 1'b1;
      m_ptr   = (win + 1) % NREQ;
    end else if (rsp_ready) begin
      m_valid = 1'b0;
    end
    chk("rsp_valid", 64'(rsp_valid), 64'(m_valid));
    if (m_valid) begin
      chk("rsp_id", 64'(rsp_id), 64'(m_id));
      chk("rsp_result", rsp_result, m_res);
      chk("rsp_zero", 64'(rsp_zero), 64'(m_zero));
      chk("rsp_negative", 64'(rsp_negative), 64'(m_neg));
      chk("rsp_overflow", 64'(rsp_overflow), 64'(m_ovf));
      chk("rsp_err", 64'(rsp_err), 64'(m_err));
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; rsp_ready = 1'b1;
    req_valid = '0; req_a = '0; req_b = '0; req_aluop = '0;

    // Reset state
    step();
    step();
    rst = 1'b0;
    chk("rst_valid", 64'(rsp_valid), 64'd0);
    chk("rst_id", 64'(rsp_id), 64'd0);
    chk("rst_result", rsp_result, 64'd0);
    chk("rst_flags", {60'd0, rsp_zero, rsp_negative, rsp_overflow, rsp_err}, 64'd0);

    // Single request, ADD 5+7 from requester 2
    set_req(2, ADD, 64'd5, 64'd7);
    step();
    drop_winner();
    chk("single_id", 64'(rsp_id), 64'd2);
    chk("single_res", rsp_result, 64'd12);
    step();

    // All four requesting: grants rotate 0,1,2,3
    do_reset();
    for (int i = 0; i < NREQ; i++) set_req(i, XOR, 64'(i * 16 + 3), 64'hFF);
    for (int k = 0; k < 8; k++) begin
      step();
      chk("rr_order", 64'(rsp_id), 64'(k % NREQ));
    end
    req_valid = '0;
    step();

    // Backpressure after SUB 0-1 from requester 1
    do_reset();
    set_req(1, SUB, 64'd0, 64'd1);
    step();
    drop_winner();
    rsp_ready = 1'b0;
    set_req(0, ADD, 64'd1, 64'd1);
    set_req(2, OR, 64'hF0, 64'h0F);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("stall_res", rsp_result, 64'hFFFF_FFFF_FFFF_FFFF);
      chk("stall_neg", 64'(rsp_negative), 64'd1);
      chk("stall_rdy", 64'(req_ready), 64'd0);
    end
    rsp_ready = 1'b1;
    step();
    drop_winner();
    chk("stall_next", 64'(rsp_id), 64'd2);
    step();
    drop_winner();
    step();

    // Signed overflow and SLT
    set_req(0, ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1);
    step();
    drop_winner();
    chk("ovf_res", rsp_result, 64'h8000_0000_0000_0000);
    chk("ovf_flag", 64'(rsp_overflow), 64'd1);
    set_req(1, SLT, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
    step();
    drop_winner();
    chk("slt_res", rsp_result, 64'd1);
    chk("slt_ovf", 64'(rsp_overflow), 64'd0);

    // Illegal opcode
    set_req(3, 4'hC, 64'd3, 64'd4);
    step();
    drop_winner();
    chk("ill_err", 64'(rsp_err), 64'd1);
    chk("ill_zero", 64'(rsp_zero), 64'd1);
    step();

    // Reset with a response pending and pointer at 3
    do_reset();
    set_req(2, AND, 64'hF, 64'h3);
    step();
    drop_winner();
    for (int i = 0; i < NREQ; i++) set_req(i, ADD, 64'(i), 64'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_valid", 64'(rsp_valid), 64'd0);
    step();
    drop_winner();
    chk("midrst_first", 64'(rsp_id), 64'd0);
    req_valid = '0;
    step();

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid[i] && $urandom_range(1, 0) == 1) begin
          if ($urandom_range(3, 0) == 0)
            set_req(i, 4'($urandom_range(15, 0)), 64'($urandom_range(3, 0)), 64'($urandom_range(3, 0)));
          else
            set_req(i, 4'($urandom_range(15, 0)), {$urandom, $urandom}, {$urandom, $urandom});
        end
      end
      rsp_ready = ($urandom_range(3, 0) != 0);
      rst = ($urandom_range(99, 0) == 0);
      step();
      drop_winner();
      rst = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
